// File: rtl/ext_pipe.sv
// Registered multi-mode immediate extender (zero/sign/LUI/branch-offset) behind a
// two-entry valid/ready skid buffer. Define EXT_OP_ERR_EN to flag reserved ext_op codes.
module ext_pipe #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  imm,
   input  logic [2:0]        ext_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ext_out,
   output logic              op_err
);

   localparam int PAD = DATA_W - IMM_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] skid;
   logic [DATA_W-1:0] ext_val;
   logic [DATA_W-1:0] zero_ext;
   logic [DATA_W-1:0] sign_ext;
   logic [DATA_W-1:0] lui_ext;
   logic [DATA_W-1:0] boff_ext;
   logic              accept;
   logic              deliver;
   logic              load_head;
   logic              load_skid;
   logic              head_from_skid;

   assign zero_ext = {{PAD{1'b0}}, imm};
   assign sign_ext = {{PAD{imm[IMM_W-1]}}, imm};
   assign lui_ext  = {imm, {PAD{1'b0}}};
   assign boff_ext = {sign_ext[DATA_W-3:0], 2'b00};

   // Entries are stored already extended so the output path is a plain register.
   always_comb begin
      ext_val = zero_ext;
      case (ext_op)
         3'd0: ext_val = zero_ext;
         3'd1: ext_val = sign_ext;
         3'd2: ext_val = lui_ext;
         3'd3: ext_val = boff_ext;
`ifdef EXT_OP_ERR_EN
         default: ext_val = '0;
`else
         default: ext_val = zero_ext;
`endif
      endcase
   end

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign ext_out   = head;
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   // Flush overrides every handshake of the cycle.
   always_comb begin
      state_nxt      = state;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_head = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  load_head = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (deliver) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (deliver) begin
                  head_from_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         state <= state_nxt;
         if (load_head) begin
            head <= ext_val;
         end else if (head_from_skid) begin
            head <= skid;
         end
         if (load_skid) begin
            skid <= ext_val;
         end
      end
   end

`ifdef EXT_OP_ERR_EN
   // Sticky until reset; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_err <= 1'b0;
      end else if (!flush && accept && ext_op[2]) begin
         op_err <= 1'b1;
      end
   end
`else
   assign op_err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ext_pipe;

   localparam int IMM_W  = 16;
   localparam int DATA_W = 32;
   localparam int PAD    = DATA_W - IMM_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [IMM_W-1:0]  imm;
   logic [2:0]        extOp;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] extOut;
   logic              op_err;

   int                assertCount = 0;
   int                failCount   = 0;
   logic [DATA_W-1:0] modelQ[$];
   logic              modelErr = 1'b0;
   logic [DATA_W-1:0] expTable[4];

   ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .imm      (imm),
      .ext_op   (extOp),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ext_out  (extOut),
      .op_err   (op_err)
   );

   always #5 clk = ~clk;

   // Reference extension from the arithmetic meaning of each mode.
   function automatic logic [DATA_W-1:0] modelExt(input logic [IMM_W-1:0] v, input logic [2:0] op);
      longint z;
      longint s;
      longint r;
      z = longint'(v);
      s = v[IMM_W-1] ? z - (longint'(1) << IMM_W) : z;
      case (op)
         3'd0: r = z;
         3'd1: r = s;
         3'd2: r = z << PAD;
         3'd3: r = s * 4;
`ifdef EXT_OP_ERR_EN
         default: r = 0;
`else
         default: r = z;
`endif
      endcase
      return r[DATA_W-1:0];
   endfunction

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [IMM_W-1:0] im, input logic [2:0] op,
                                input logic ordy, input logic fl);
      in_valid  = v;
      imm       = im;
      extOp     = op;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   // FIFO model of up to two entries; flush and reset empty it.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         modelQ.delete();
         modelErr = 1'b0;
      end else begin
         bit acc;
         bit dlv;
         acc = in_valid && (modelQ.size() < 2);
         dlv = out_ready && (modelQ.size() > 0);
         if (flush) begin
            modelQ.delete();
         end else begin
            if (dlv) void'(modelQ.pop_front());
            if (acc) begin
               modelQ.push_back(modelExt(imm, extOp));
`ifdef EXT_OP_ERR_EN
               if (extOp >= 3'd4) modelErr = 1'b1;
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checkOutput("model out_valid", {31'b0, out_valid}, {31'b0, modelQ.size() != 0});
         checkOutput("model in_ready", {31'b0, in_ready}, {31'b0, modelQ.size() != 2});
         if (modelQ.size() > 0) checkOutput("model ext_out", extOut, modelQ[0]);
         checkOutput("model op_err", {31'b0, op_err}, {31'b0, modelErr});
      end
   end

   initial begin
      expTable[0] = 32'h0000_8001;
      expTable[1] = 32'hFFFF_8001;
      expTable[2] = 32'h8001_0000;
      expTable[3] = 32'hFFFE_0004;

      reset = 1'b0;
      in_valid = 1'b0; imm = '0; extOp = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset ext_out", extOut, 32'd0);
      checkOutput("reset op_err", {31'b0, op_err}, 32'd0);
      reset = 1'b1;

      // Basic modes, one cycle after acceptance each.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'h8001, 3'(i), 1'b1, 1'b0);
         checkOutput("mode out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("mode ext_out", extOut, expTable[i]);
      end
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
      checkOutput("drain out_valid", {31'b0, out_valid}, 32'd0);

      // Back-pressure: A, B fill the buffer, C waits.
      applyStimulus(1'b1, 16'h0001, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7FFF, 3'd1, 1'b0, 1'b0);
      checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 16'hABCD, 3'd0, 1'b0, 1'b0);
      checkOutput("bp hold A", extOut, 32'h0000_0001);
      applyStimulus(1'b1, 16'hABCD, 3'd0, 1'b1, 1'b0);
      checkOutput("bp B", extOut, 32'h0000_7FFF);
      checkOutput("bp in_ready high", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, 16'hABCD, 3'd0, 1'b1, 1'b0);
      checkOutput("bp C", extOut, 32'h0000_ABCD);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

      // Steady accept+deliver at one entry.
      applyStimulus(1'b1, 16'h0100, 3'd1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 16'h0200 + 16'(i), 3'd2, 1'b1, 1'b0);
         checkOutput("stream in_ready", {31'b0, in_ready}, 32'd1);
         checkOutput("stream ext_out", extOut, {16'h0200 + 16'(i), 16'h0000});
      end
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

      // Flush with a full buffer and a concurrent input.
      applyStimulus(1'b1, 16'h1111, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h2222, 3'd0, 1'b0, 1'b0);
      checkOutput("pre-flush in_ready", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 16'h3333, 3'd0, 1'b1, 1'b1);
      checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush in_ready", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
      checkOutput("post-flush empty", {31'b0, out_valid}, 32'd0);

      // Reserved mode.
      applyStimulus(1'b1, 16'h1234, 3'd5, 1'b1, 1'b0);
`ifdef EXT_OP_ERR_EN
      checkOutput("reserved ext_out", extOut, 32'h0000_0000);
      checkOutput("reserved op_err", {31'b0, op_err}, 32'd1);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b1);
      checkOutput("op_err after flush", {31'b0, op_err}, 32'd1);
`else
      checkOutput("reserved ext_out", extOut, 32'h0000_1234);
      checkOutput("reserved op_err", {31'b0, op_err}, 32'd0);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b1);
      checkOutput("op_err after flush", {31'b0, op_err}, 32'd0);
`endif

      // Asynchronous reset between edges with two entries buffered.
      applyStimulus(1'b1, 16'h5555, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h6666, 3'd1, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async ext_out", extOut, 32'd0);
      checkOutput("async in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("async op_err", {31'b0, op_err}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 16'h0042, 3'd0, 1'b1, 1'b0);
      checkOutput("post-reset out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("post-reset ext_out", extOut, 32'h0000_0042);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
